// File: rtl/fft_frame_indexer.sv
// FFT output framer: tags each sample with its bin index, a frame number on tuser and the
// frame's cutoff, regenerates tlast, and flags malformed frames. Output register plus a
// one-entry skid register provide backpressure.
// Optional: define FFT_FRAME_INDEXER_BITREV_EN to present m_index in bit-reversed order.
module fft_frame_indexer #(
  parameter int unsigned DATA_LEN  = 64,
  parameter int unsigned FFT_LEN   = 8192,
  parameter int unsigned TUSER_LEN = 32,
  parameter int unsigned INDEX_LEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_LEN-1:0]  s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic [INDEX_LEN-1:0] cutoff_in,
  input  logic                 cutoff_wr,
  output logic [DATA_LEN-1:0]  m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [TUSER_LEN-1:0] m_tuser,
  output logic [INDEX_LEN-1:0] m_index,
  output logic [INDEX_LEN-1:0] m_cutoff,
  output logic                 frame_err,
  output logic [TUSER_LEN-1:0] frame_count
);

  localparam int unsigned CntW = $clog2(FFT_LEN);
  localparam logic [CntW-1:0] LastIdx = CntW'(FFT_LEN - 1);
  localparam logic [INDEX_LEN-1:0] CutoffRst = INDEX_LEN'(FFT_LEN / 2);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StFrame = 1'b1;

  typedef struct packed {
    logic [DATA_LEN-1:0]  data;
    logic                 last;
    logic [TUSER_LEN-1:0] user;
    logic [INDEX_LEN-1:0] index;
    logic [INDEX_LEN-1:0] cutoff;
  } beat_t;

  localparam beat_t BeatRst = '{data: '0, last: 1'b0, user: '0, index: '0, cutoff: CutoffRst};

  logic [0:0]           state_q, state_d;
  logic [CntW-1:0]      idx_q, idx_d;
  logic [TUSER_LEN-1:0] frame_q, frame_d;
  logic [INDEX_LEN-1:0] shadow_q, shadow_d;
  logic [INDEX_LEN-1:0] cutoff_q, cutoff_d;
  logic                 err_q, err_d;
  logic [TUSER_LEN-1:0] fcount_q, fcount_d;
  beat_t                out_q, out_d;
  beat_t                skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 ready_q, ready_d;

  logic                 accept;
  logic                 out_fire;
  logic                 at_last;
  logic                 frame_end;
  logic [INDEX_LEN-1:0] shadow_eff;
  logic [INDEX_LEN-1:0] beat_cutoff;
  logic [INDEX_LEN-1:0] idx_ext;
  beat_t                in_beat;

  assign accept   = s_tvalid & ready_q;
  assign out_fire = out_valid_q & m_tready;

  // Presented bin index: natural counter or its bit-reversal, zero-extended.
  always_comb begin
    idx_ext = '0;
`ifdef FFT_FRAME_INDEXER_BITREV_EN
    for (int i = 0; i < int'(CntW); i++) begin
      idx_ext[i] = idx_q[CntW-1-i];
    end
`else
    idx_ext[CntW-1:0] = idx_q;
`endif
  end

  // Framing: index counter, frame number, cutoff capture and malformed-frame detection.
  always_comb begin
    at_last     = (idx_q == LastIdx);
    // A missing tlast at the last bin forces the frame end.
    frame_end   = s_tlast | at_last;
    // A write coinciding with the index-0 accept must already apply to that frame.
    shadow_eff  = cutoff_wr ? cutoff_in : shadow_q;
    beat_cutoff = (state_q == StIdle) ? shadow_eff : cutoff_q;

    in_beat.data   = s_tdata;
    in_beat.last   = frame_end;
    in_beat.user   = frame_q;
    in_beat.index  = idx_ext;
    in_beat.cutoff = beat_cutoff;

    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    cutoff_d = cutoff_q;
    shadow_d = shadow_eff;
    err_d    = 1'b0;
    if (accept) begin
      cutoff_d = beat_cutoff;
      // Short frame (early tlast) or long frame (no tlast at last bin).
      err_d    = s_tlast ^ at_last;
      if (frame_end) begin
        state_d = StIdle;
        idx_d   = '0;
        frame_d = frame_q + TUSER_LEN'(1);
      end else begin
        state_d = StFrame;
        idx_d   = idx_q + CntW'(1);
      end
    end
  end

  // Output register and skid register; ready is registered as "skid empty".
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m_tready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
    ready_d  = ~skid_valid_d;
    fcount_d = fcount_q + TUSER_LEN'(out_fire & out_q.last);
  end

  // State registers with synchronous reset; reset drops any partial frame and buffered beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      frame_q      <= '0;
      shadow_q     <= CutoffRst;
      cutoff_q     <= CutoffRst;
      err_q        <= 1'b0;
      fcount_q     <= '0;
      out_q        <= BeatRst;
      skid_q       <= BeatRst;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      shadow_q     <= shadow_d;
      cutoff_q     <= cutoff_d;
      err_q        <= err_d;
      fcount_q     <= fcount_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign s_tready    = ready_q;
  assign m_tvalid    = out_valid_q;
  assign m_tdata     = out_q.data;
  assign m_tlast     = out_q.last;
  assign m_tuser     = out_q.user;
  assign m_index     = out_q.index;
  assign m_cutoff    = out_q.cutoff;
  assign frame_err   = err_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_fft_frame_indexer.sv
// Directed bench for fft_frame_indexer with FFT_LEN=16: normal, stalled, short, long,
// cutoff-update and mid-frame-reset frames, checked against a small reference model.
module tb_fft_frame_indexer;

  localparam int unsigned DW = 32;
  localparam int unsigned FL = 16;
  localparam int unsigned TW = 8;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [IW-1:0] cutoff_in = '0;
  logic          cutoff_wr = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [TW-1:0] m_tuser;
  logic [IW-1:0] m_index;
  logic [IW-1:0] m_cutoff;
  logic          frame_err;
  logic [TW-1:0] frame_count;

  fft_frame_indexer #(
    .DATA_LEN (DW),
    .FFT_LEN  (FL),
    .TUSER_LEN(TW),
    .INDEX_LEN(IW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .cutoff_in  (cutoff_in),
    .cutoff_wr  (cutoff_wr),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .m_index    (m_index),
    .m_cutoff   (m_cutoff),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [TW-1:0] user;
    logic [IW-1:0] index;
    logic [IW-1:0] cutoff;
  } exp_t;

  int            checks = 0;
  int            failures = 0;
  exp_t          sb[$];
  logic [IW-1:0] cut_seen[$];
  int unsigned   md_idx;
  logic [TW-1:0] md_frame;
  logic [IW-1:0] md_shadow;
  logic [IW-1:0] md_fcut;
  logic [DW-1:0] data_seq = 32'hD000_0000;
  bit            last_acc;
  int            err_pulses = 0;
  int            cyc_used;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] exp_index(input int unsigned n);
    logic [IW-1:0] r;
    r = '0;
`ifdef FFT_FRAME_INDEXER_BITREV_EN
    for (int i = 0; i < 4; i++) r[i] = n[3-i];
`else
    r = IW'(n);
`endif
    return r;
  endfunction

  function automatic void model_reset();
    sb.delete();
    md_idx    = 0;
    md_frame  = '0;
    md_shadow = IW'(FL / 2);
    md_fcut   = IW'(FL / 2);
  endfunction

  // One clock: score the handshakes about to happen, advance, then check registered outputs.
  task automatic step();
    bit            acc, fire, exp_err, hold;
    logic [63:0]   held;
    exp_t          e;
    logic [IW-1:0] eff;
    acc     = s_tvalid && s_tready;
    fire    = m_tvalid && m_tready;
    exp_err = 1'b0;
    hold    = m_tvalid && !m_tready;
    held    = {22'd0, m_tvalid, m_tlast, m_index, m_tdata};
    last_acc = acc;
    if (fire) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("m_tdata", m_tdata, e.data);
        check("m_tlast", m_tlast, e.last);
        check("m_tuser", m_tuser, e.user);
        check("m_index", m_index, e.index);
        check("m_cutoff", m_cutoff, e.cutoff);
        if (m_index == 0) cut_seen.push_back(m_cutoff);
      end
    end
    if (acc) begin
      eff = cutoff_wr ? cutoff_in : md_shadow;
      if (md_idx == 0) md_fcut = eff;
      e.data   = s_tdata;
      e.last   = s_tlast || (md_idx == FL - 1);
      e.user   = md_frame;
      e.index  = exp_index(md_idx);
      e.cutoff = md_fcut;
      exp_err  = s_tlast != (md_idx == FL - 1);
      sb.push_back(e);
      if (e.last) begin
        md_idx   = 0;
        md_frame = md_frame + 1'b1;
      end else begin
        md_idx++;
      end
      data_seq++;
    end
    if (cutoff_wr) md_shadow = cutoff_in;
    @(posedge clk);
    #1;
    check("frame_err", frame_err, exp_err);
    if (frame_err) err_pulses++;
    if (hold) check("stall_hold", {22'd0, m_tvalid, m_tlast, m_index, m_tdata}, held);
    check("s_tready_skid", s_tready, sb.size() < 2);
  endtask

  // Send n beats (tlast where tlast_mask is set) and drain the output.
  task automatic run(input int n, input logic [63:0] tlast_mask, input bit rand_ready,
                     input int wr_beat, input logic [IW-1:0] wr_val, output int cycles);
    int sent = 0;
    int cyc = 0;
    while ((sent < n || sb.size() != 0) && cyc < 500) begin
      s_tvalid  = sent < n;
      s_tdata   = data_seq;
      s_tlast   = s_tvalid && tlast_mask[sent];
      cutoff_wr = s_tvalid && (sent == wr_beat);
      cutoff_in = wr_val;
      if (rand_ready) m_tready = (cyc >= 4) && ($urandom_range(0, 99) < 50);
      else m_tready = 1'b1;
      step();
      if (last_acc) sent++;
      cyc++;
    end
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    cutoff_wr = 1'b0;
    m_tready  = 1'b1;
    check("all_sent", 64'(sent), 64'(n));
    check("drained", 64'(sb.size()), 64'd0);
    cycles = cyc;
  endtask

  task automatic apply_reset();
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    cutoff_wr = 1'b0;
    m_tready  = 1'b1;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tdata", m_tdata, '0);
    check("rst_m_index", m_index, '0);
    check("rst_m_tuser", m_tuser, '0);
    check("rst_m_cutoff", m_cutoff, 64'd8);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_frame_count", frame_count, '0);
    check("rst_s_tready", s_tready, 1'b0);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("s_tready_after_rst", s_tready, 1'b1);
  endtask

  initial begin
    apply_reset();

    // Two well-formed frames at full rate.
    run(32, (64'd1 << 15) | (64'd1 << 31), 1'b0, -1, '0, cyc_used);
    check("throughput", 64'(cyc_used), 64'd33);
    check("fc_two_frames", frame_count, 64'd2);
    check("err_none", 64'(err_pulses), 64'd0);

    // One frame with random downstream stalls.
    run(16, 64'd1 << 15, 1'b1, -1, '0, cyc_used);
    check("fc_stalled", frame_count, 64'd3);
    check("err_stalled", 64'(err_pulses), 64'd0);

    // Short frame (tlast on beat 9), then a normal frame.
    run(26, (64'd1 << 9) | (64'd1 << 25), 1'b0, -1, '0, cyc_used);
    check("fc_short", frame_count, 64'd5);
    check("err_short", 64'(err_pulses), 64'd1);

    // Long frame (no tlast at 15), then a normal frame.
    run(32, 64'd1 << 31, 1'b0, -1, '0, cyc_used);
    check("fc_long", frame_count, 64'd7);
    check("err_long", 64'(err_pulses), 64'd2);

    // Cutoff written mid-frame takes effect on the next frame; write at index 0 applies at once.
    cut_seen.delete();
    run(32, (64'd1 << 15) | (64'd1 << 31), 1'b0, 5, 8'd100, cyc_used);
    run(16, 64'd1 << 15, 1'b0, 0, 8'd37, cyc_used);
    check("cut_seen_cnt", 64'(cut_seen.size()), 64'd3);
    if (cut_seen.size() == 3) begin
      check("cutoff_frame_a", cut_seen[0], 64'd8);
      check("cutoff_frame_b", cut_seen[1], 64'd100);
      check("cutoff_frame_c", cut_seen[2], 64'd37);
    end
    check("fc_cutoff", frame_count, 64'd10);
    check("err_cutoff", 64'(err_pulses), 64'd2);

    // Reset with beats buffered mid-frame; next frame restarts at index 0, frame 0, cutoff 8.
    m_tready = 1'b0;
    s_tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = data_seq;
      step();
    end
    apply_reset();
    cut_seen.delete();
    run(16, 64'd1 << 15, 1'b0, -1, '0, cyc_used);
    check("fc_after_rst", frame_count, 64'd1);
    check("cutoff_after_rst", 64'(cut_seen.size() > 0 ? cut_seen[0] : 8'hFF), 64'd8);
    check("err_after_rst", 64'(err_pulses), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_indexer.md
Name: fft_frame_indexer

Overview:
- Producer-side framer for the frequency-domain filter path.
- Takes the raw FFT output stream and emits an AXI-Stream that carries the per-sample bin index, a frame counter on tuser, a regenerated tlast, and a cutoff value held constant for the whole frame.
- Sits between the FFT core and the frequency-domain LPF/processing chain.
- Adds backpressure (tready) with a skid buffer and detects malformed frames.

Parameters:
- DATA_LEN, 64, sample width (packed I/Q)
- FFT_LEN, 8192, bins per frame; power of two, >= 4
- TUSER_LEN, 32, frame counter width
- INDEX_LEN, 32, bin index width; must be >= log2(FFT_LEN)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- s_tdata  in  DATA_LEN  FFT output sample
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  FFT end-of-frame marker
- cutoff_in  in  INDEX_LEN  new cutoff bin
- cutoff_wr  in  1  one-cycle write strobe for cutoff_in
- m_tdata  out  DATA_LEN  sample
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  regenerated end-of-frame
- m_tuser  out  TUSER_LEN  frame number
- m_index  out  INDEX_LEN  bin index within frame
- m_cutoff  out  INDEX_LEN  cutoff applied to this frame
- frame_err  out  1  one-cycle pulse on a tlast/length mismatch
- frame_count  out  TUSER_LEN  completed frames

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values:
  - m_tvalid=0, m_tlast=0, m_tdata=0, m_index=0, m_tuser=0.
  - m_cutoff=FFT_LEN/2; cutoff shadow register=FFT_LEN/2.
  - frame_err=0, frame_count=0, s_tready=0.
  - s_tready rises the first cycle after reset deasserts.
- Reset mid-frame discards the partial frame and any buffered beats. The next accepted beat is index 0 of frame 0.
- Datapath: output register plus a one-entry skid register.
  - s_tready is registered and equals "skid empty".
  - Input accepted on s_tvalid&s_tready; output transferred on m_tvalid&m_tready.
  - Latency is 1 cycle from input handshake to m_tvalid when the output stage is empty or draining.
  - Throughput is 1 beat/cycle while m_tready=1.
  - With m_tready=0 and the output stage full, the next accepted beat goes to the skid register and s_tready drops on the following cycle. No beat is lost or duplicated.
  - m_* payload is stable while m_tvalid=1 and m_tready=0.
- Index counter (natural order, 0..FFT_LEN-1):
  - Increments on each accepted input beat.
  - Wraps to 0 after FFT_LEN-1 or after a forced frame end.
- State machine:
  - IDLE → FRAME on an accepted beat; that beat is index 0.
  - FRAME → IDLE on an accepted beat that ends the frame.
  - FRAME holds otherwise.
- Frame end rules:
  - Index FFT_LEN-1 with s_tlast=1: normal end. m_tlast=1.
  - Index < FFT_LEN-1 with s_tlast=1 (short frame): m_tlast=1 on that beat, frame_err pulses, counter restarts at 0.
  - Index FFT_LEN-1 with s_tlast=0 (long frame): m_tlast=1 is forced, frame_err pulses, and the next beat starts a new frame at index 0.
  - frame_err pulses in the cycle after the offending input handshake.
- tuser and frame counting:
  - m_tuser holds the frame number for every beat of the frame.
  - The frame number increments after each frame end (normal or forced) and wraps modulo 2^TUSER_LEN.
  - frame_count increments when the m_tlast beat completes its output handshake.
- Cutoff:
  - cutoff_wr loads the shadow register at any time.
  - The shadow register is copied into the frame cutoff on the accepted index-0 beat; m_cutoff holds that value for the whole frame.
  - If cutoff_wr coincides with the index-0 accept, the new cutoff_in value is used for that frame.
- Indices are zero-extended to INDEX_LEN.

Optional Feature:
- Macro: FFT_FRAME_INDEXER_BITREV_EN.
- Defined: m_index carries the bit-reversal of the low log2(FFT_LEN) bits of the natural counter (upper bits 0), for FFT cores emitting bit-reversed order. Framing, tlast and error logic still use the natural counter.
- Undefined: m_index equals the natural counter.

Test Plan:
- Reset, then 2 frames of FFT_LEN=16 with s_tlast on beat 15 and m_tready=1 → m_index 0..15 twice; m_tlast on beats 15 and 31; m_tuser 0 then 1; frame_err never; frame_count=2.
- m_tready toggled pseudo-randomly during a 16-beat frame → all 16 beats delivered in order, no loss or duplication; s_tready deasserts only when skid is full; payload stable under stall.
- s_tlast on beat 9 (short frame) → m_tlast on index 9, one frame_err pulse, next beat has index 0 and m_tuser incremented.
- No s_tlast at beat 15 → m_tlast forced at index 15, frame_err pulses, beat 16 emitted with index 0 of the next frame.
- cutoff_wr=1 with cutoff_in=100 mid-frame → m_cutoff keeps 8 (FFT_LEN/2) until the next index-0 beat, then 100; cutoff_wr on the index-0 cycle with 37 → that frame shows 37.
- With FFT_FRAME_INDEXER_BITREV_EN, FFT_LEN=16 → m_index sequence 0,8,4,12,2,…,15; m_tlast still on the 16th beat.
